// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU replacement state for a set-associative cache.
// Serves READ/TOUCH/FILL requests and a multi-cycle FLUSH sweep over all sets.
module cache_plru_tree #(
  parameter int unsigned WAYS     = 8,
  parameter int unsigned WAYS_REP = $clog2(WAYS),
  parameter int unsigned SETS     = 64,
  parameter int unsigned INDEX    = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [INDEX-1:0]    req_set,
  input  logic [WAYS_REP-1:0] req_way,
  output logic                rsp_valid,
  output logic [WAYS_REP-1:0] rsp_way,
  output logic [INDEX-1:0]    rsp_set,
  output logic                busy,
  output logic                flush_done
);

  localparam int unsigned NODES = WAYS - 1;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_TOUCH = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;
  localparam logic [INDEX-1:0] LAST_SET = INDEX'(SETS - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  // Walk from the root: a set bit steers toward the lower ways.
  function automatic logic [WAYS_REP-1:0] victim_of(input logic [NODES-1:0] bits);
    logic [WAYS-1:0]     tree;
    logic [WAYS_REP-1:0] node;
    logic [WAYS_REP-1:0] way;
    logic                dir;
    tree = {1'b0, bits};
    node = '0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < WAYS_REP; lvl++) begin
      dir  = ~tree[node];
      way  = WAYS_REP'({way, dir});
      node = WAYS_REP'({node, 1'b0}) + (dir ? WAYS_REP'(2) : WAYS_REP'(1));
    end
    return way;
  endfunction

  // Point every node on the way's path away from it.
  function automatic logic [NODES-1:0] mru_of(input logic [NODES-1:0] bits,
                                              input logic [WAYS_REP-1:0] way);
    logic [WAYS-1:0]     tree;
    logic [WAYS_REP-1:0] node;
    logic [WAYS_REP-1:0] path;
    logic                dir;
    tree = {1'b0, bits};
    node = '0;
    path = way;
    for (int unsigned lvl = 0; lvl < WAYS_REP; lvl++) begin
      dir        = path[WAYS_REP-1];
      path       = WAYS_REP'({path, 1'b0});
      tree[node] = dir;
      node       = WAYS_REP'({node, 1'b0}) + (dir ? WAYS_REP'(2) : WAYS_REP'(1));
    end
    return tree[NODES-1:0];
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [INDEX-1:0]    cnt_q;
  logic [NODES-1:0]    plru_q [SETS];
  logic [NODES-1:0]    cur_bits;
  logic [WAYS_REP-1:0] victim;
  logic [NODES-1:0]    touch_bits;
  logic [NODES-1:0]    fill_bits;
  logic                accept;

  assign accept     = req_valid && req_ready;
  assign cur_bits   = plru_q[req_set];
  assign victim     = victim_of(cur_bits);
  assign touch_bits = mru_of(cur_bits, req_way);
  assign fill_bits  = mru_of(cur_bits, victim);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && req_op == OP_FLUSH) state_d = S_FLUSH;
      S_FLUSH: if (cnt_q == LAST_SET) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_FLUSH: busy      = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Flush sweep owns the array; otherwise accepted TOUCH/FILL write their set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plru_q <= '{default: '0};
    end else if (state_q == S_FLUSH) begin
      plru_q[cnt_q] <= '0;
    end else if (accept && req_op == OP_TOUCH) begin
      plru_q[req_set] <= touch_bits;
    end else if (accept && req_op == OP_FILL) begin
      plru_q[req_set] <= fill_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state_q == S_FLUSH) && (cnt_q == LAST_SET);
      if (state_q == S_FLUSH)                    cnt_q <= cnt_q + INDEX'(1);
      else if (accept && req_op == OP_FLUSH)     cnt_q <= '0;
    end
  end

  // Response carries the pre-update victim; way/set hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_way   <= '0;
      rsp_set   <= '0;
    end else begin
      rsp_valid <= accept && (req_op == OP_READ || req_op == OP_FILL);
      if (accept && (req_op == OP_READ || req_op == OP_FILL)) begin
        rsp_way <= victim;
        rsp_set <= req_set;
      end
    end
  end

endmodule
